// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: widths, load-size encodings and the
// hard-wired zero register index.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte/half-word out of a
// 32-bit memory word and sign- or zero-extends it. Shared with store merge.
module load_align
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        fill;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
  end

  // off[0] is ignored for half-words: misaligned halves are not trapped here
  assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    fill   = 1'b0;
    data_o = word_i;
    case (size_i)
      LS_BYTE: begin
        fill   = ~unsigned_i & byte_sel[7];
        data_o = {{24{fill}}, byte_sel};
      end
      LS_HALF: begin
        fill   = ~unsigned_i & half_sel[15];
        data_o = {{16{fill}}, half_sel};
      end
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback stage: drives the register file
// write port (committed on the falling edge), forwarding taps and a retire count.
module mem_wb_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_reg_write,
  input  logic               in_mem_to_reg,
  input  logic               in_link,
  input  logic [ADDR_W-1:0]  in_rd,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic [DATA_W-1:0]  in_mem_data,
  input  logic [DATA_W-1:0]  in_pc_plus4,
  input  logic [1:0]         in_load_size,
  input  logic               in_load_unsigned,
  output logic               reg_write,
  output logic [ADDR_W-1:0]  write_addr,
  output logic [DATA_W-1:0]  write_data,
  output logic               fwd_valid,
  output logic [ADDR_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
  output logic [COUNT_W-1:0] retire_count
);

  logic               valid_q;
  logic               reg_write_q;
  logic               mem_to_reg_q;
  logic               link_q;
  logic [ADDR_W-1:0]  rd_q;
  logic [DATA_W-1:0]  alu_q;
  logic [DATA_W-1:0]  mem_q;
  logic [DATA_W-1:0]  pc_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;

  logic [DATA_W-1:0]  load_data;
  logic [DATA_W-1:0]  wb_data;
  logic               wb_en;

  // Retirement is counted when a valid instruction enters the stage, so the
  // count already includes the instruction currently on the write port.
  assign cnt_d = cnt_q + COUNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      link_q       <= 1'b0;
      rd_q         <= '0;
      alu_q        <= '0;
      mem_q        <= '0;
      pc_q         <= '0;
      size_q       <= LS_BYTE;
      uns_q        <= 1'b0;
      cnt_q        <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q      <= in_valid;
      reg_write_q  <= in_reg_write;
      mem_to_reg_q <= in_mem_to_reg;
      link_q       <= in_link;
      rd_q         <= in_rd;
      alu_q        <= in_alu_result;
      mem_q        <= in_mem_data;
      pc_q         <= in_pc_plus4;
      size_q       <= in_load_size;
      uns_q        <= in_load_unsigned;
      if (in_valid) cnt_q <= cnt_d;
    end
  end

  load_align u_align (
    .word_i     (mem_q),
    .off_i      (alu_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  always_comb begin
    if (link_q)            wb_data = pc_q;
    else if (mem_to_reg_q) wb_data = load_data;
    else                   wb_data = alu_q;
  end

  assign wb_en = valid_q & reg_write_q & (rd_q != REG_ZERO);

  assign reg_write    = wb_en;
  assign write_addr   = rd_q;
  assign write_data   = wb_data;
  assign fwd_valid    = wb_en;
  assign fwd_rd       = rd_q;
  assign fwd_data     = wb_data;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed + randomized bench for mem_wb_writeback against a behavioural model.
module tb_mem_wb_writeback;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, stall, flush;
  logic          in_valid, in_reg_write, in_mem_to_reg, in_link;
  logic [4:0]    in_rd;
  logic [31:0]   in_alu_result, in_mem_data, in_pc_plus4;
  logic [1:0]    in_load_size;
  logic          in_load_unsigned;
  logic          reg_write, fwd_valid;
  logic [4:0]    write_addr, fwd_rd;
  logic [31:0]   write_data, fwd_data;
  logic [CW-1:0] retire_count;

  int checks = 0;
  int errors = 0;

  // model of the stage: the last accepted instruction and the retire total
  logic        m_valid, m_rw, m_m2r, m_link, m_uns;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_mem, m_pc;
  logic [1:0]  m_size;
  int          m_cnt;

  always #5 clk = ~clk;

  mem_wb_writeback #(.DATA_W(32), .ADDR_W(5), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_link(in_link), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_pc_plus4(in_pc_plus4), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned),
    .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  function automatic logic [31:0] ref_data();
    int unsigned off, v;
    off = m_alu % 4;
    if (m_link) return m_pc;
    if (!m_m2r) return m_alu;
    if (m_size == 2'd0) begin
      v = (m_mem >> (8 * off)) % 256;
      if (!m_uns && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (m_size == 2'd1) begin
      v = (m_mem >> (16 * (off / 2))) % 65536;
      if (!m_uns && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return m_mem;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic        we;
    logic [31:0] d;
    we = m_valid && m_rw && (m_rd != 0);
    d  = ref_data();
    chk({tag, ".we"}, 32'(reg_write), 32'(we));
    chk({tag, ".addr"}, 32'(write_addr), 32'(m_rd));
    chk({tag, ".data"}, write_data, d);
    chk({tag, ".fwd_v"}, 32'(fwd_valid), 32'(we));
    chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(m_rd));
    chk({tag, ".fwd_d"}, fwd_data, d);
    chk({tag, ".cnt"}, 32'(retire_count), 32'(m_cnt % (1 << CW)));
  endtask

  task automatic model_edge();
    if (!rst) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_link = 0; m_uns = 0;
      m_rd = 0; m_alu = 0; m_mem = 0; m_pc = 0; m_size = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (!stall) begin
      m_valid = in_valid; m_rw = in_reg_write; m_m2r = in_mem_to_reg;
      m_link = in_link; m_rd = in_rd; m_alu = in_alu_result;
      m_mem = in_mem_data; m_pc = in_pc_plus4; m_size = in_load_size;
      m_uns = in_load_unsigned;
      if (in_valid) m_cnt++;
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic ld(input logic v, input logic rw, input logic m2r, input logic lk,
                    input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                    input logic [31:0] pc, input logic [1:0] sz, input logic uns);
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_link = lk;
    in_rd = rd; in_alu_result = alu; in_mem_data = mem; in_pc_plus4 = pc;
    in_load_size = sz; in_load_unsigned = uns;
  endtask

  initial begin
    int saved;
    rst = 0; stall = 0; flush = 0;
    ld(1, 1, 0, 0, 5'd9, 32'hDEAD, 32'hBEEF, 32'h4, 2'd2, 0);
    cycle("rst0");
    cycle("rst1");
    chk("rst.we", 32'(reg_write), 32'd0);
    chk("rst.data", write_data, 32'd0);
    chk("rst.cnt", 32'(retire_count), 32'd0);
    rst = 1;

    ld(1, 1, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 2'd2, 0);
    cycle("alu");
    chk("alu.we", 32'(reg_write), 32'd1);
    chk("alu.addr", 32'(write_addr), 32'd5);
    chk("alu.data", write_data, 32'h1234);
    chk("alu.cnt", 32'(retire_count), 32'd1);
    ld(1, 1, 0, 0, 5'd0, 32'h1234, 32'h0, 32'h0, 2'd2, 0);
    cycle("r0");
    chk("r0.we", 32'(reg_write), 32'd0);
    chk("r0.cnt", 32'(retire_count), 32'd2);

    ld(1, 1, 1, 0, 5'd3, 32'h103, 32'h80FF7F01, 32'h0, 2'd0, 0);
    cycle("lb3");
    chk("lb3.data", write_data, 32'hFFFFFF80);
    ld(1, 1, 1, 0, 5'd3, 32'h101, 32'h80FF7F01, 32'h0, 2'd0, 1);
    cycle("lbu1");
    chk("lbu1.data", write_data, 32'h0000007F);
    ld(1, 1, 1, 0, 5'd3, 32'h102, 32'h80FF7F01, 32'h0, 2'd1, 0);
    cycle("lh2");
    chk("lh2.data", write_data, 32'hFFFF80FF);
    ld(1, 1, 1, 0, 5'd3, 32'h103, 32'h80FF7F01, 32'h0, 2'd1, 1);
    cycle("lhu3");
    chk("lhu3.data", write_data, 32'h000080FF);
    ld(1, 1, 1, 0, 5'd3, 32'h102, 32'h80FF7F01, 32'h0, 2'd2, 0);
    cycle("lw");
    chk("lw.data", write_data, 32'h80FF7F01);
    ld(1, 1, 1, 0, 5'd3, 32'h101, 32'h80FF7F01, 32'h0, 2'd3, 0);
    cycle("lw3");
    chk("lw3.data", write_data, 32'h80FF7F01);

    ld(1, 1, 1, 1, 5'd31, 32'h7, 32'h80FF7F01, 32'h40, 2'd2, 0);
    cycle("jal");
    chk("jal.addr", 32'(write_addr), 32'd31);
    chk("jal.data", write_data, 32'h40);

    ld(1, 1, 0, 0, 5'd7, 32'h55, 32'h0, 32'h0, 2'd2, 0);
    cycle("pre_stall");
    saved = int'(retire_count);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ld(1, 1, 0, 0, 5'(i + 10), $urandom, $urandom, $urandom, 2'd2, 0);
      cycle("stall");
      chk("stall.data", write_data, 32'h55);
      chk("stall.cnt", 32'(retire_count), 32'(saved));
    end
    flush = 1;
    cycle("stall_flush");
    chk("sflush.we", 32'(reg_write), 32'd0);
    chk("sflush.cnt", 32'(retire_count), 32'(saved));
    stall = 0; flush = 0;

    ld(1, 1, 0, 0, 5'd4, 32'h99, 32'h0, 32'h0, 2'd2, 0);
    cycle("pre_rst");
    rst = 0;
    cycle("mid_rst");
    chk("midrst.we", 32'(reg_write), 32'd0);
    rst = 1;

    for (int i = 0; i < 40 && (m_cnt % (1 << CW)) != (1 << CW) - 1; i++) begin
      ld(1, 1, 0, 0, 5'd2, 32'(i), 32'h0, 32'h0, 2'd2, 0);
      cycle("fill");
    end
    chk("wrap.pre", 32'(retire_count), 32'((1 << CW) - 1));
    ld(1, 1, 0, 0, 5'd2, 32'hAA, 32'h0, 32'h0, 2'd2, 0);
    cycle("wrap");
    chk("wrap.cnt", 32'(retire_count), 32'd0);

    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 39) != 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      ld($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
         $urandom_range(0, 5) == 0, 5'($urandom_range(0, 31)), $urandom, $urandom,
         $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
